// File: rtl/if_prefetch_unit.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : if_prefetch_unit
// Description : Instruction-fetch front end. Issues sequential word-aligned
//               fetch addresses to instruction memory over a valid/ready
//               request channel. Buffers in-order responses in a DEPTH-entry
//               prefetch FIFO. Presents {pc, instruction} pairs to the ID
//               stage. A redirect from EX flushes the FIFO and discards
//               responses that are still outstanding.
//
// Ports       : clk             - clock, rising edge
//               reset           - asynchronous, active-high
//               imem_req_valid  - fetch request valid
//               imem_req_ready  - memory accepts request
//               imem_req_addr   - fetch address (word aligned)
//               imem_resp_valid - in-order response valid
//               imem_resp_data  - fetched instruction
//               id_valid        - head entry valid to ID
//               id_ready        - ID consumes head
//               id_pc           - pc of head entry
//               id_instr        - instruction of head entry
//               redirect_valid  - flush and restart fetch
//               redirect_pc     - restart pc (bits [1:0] forced to zero)
//
// Revision    : 1.0 - initial release
// ============================================================================
module if_prefetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    // Pointer width indexes DEPTH entries; counter width holds 0..DEPTH.
    localparam int unsigned  c_ptr_w = $clog2(DEPTH);
    localparam int unsigned  c_cnt_w = $clog2(DEPTH) + 1;
    localparam logic [c_cnt_w:0] c_depth = (c_cnt_w + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [XLEN-1:0]    r_fetch_pc;
    logic [XLEN-1:0]    r_resp_pc;
    logic [XLEN-1:0]    r_pc_mem    [DEPTH];
    logic [XLEN-1:0]    r_instr_mem [DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [c_cnt_w-1:0] r_inflight;
    logic [c_cnt_w-1:0] r_drop_cnt;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic [c_cnt_w:0]   w_occupancy;
    logic               w_req_fire;
    logic               w_resp_ok;
    logic               w_resp_drop;
    logic               w_push;
    logic               w_pop;
    logic [c_cnt_w-1:0] w_inflight_next;
    logic [XLEN-1:0]    w_redirect_aligned;
    logic               w_unused_redirect_lsbs;

    // Credit: every FIFO slot is reserved either by a buffered entry or by
    // an outstanding request, so a response can always be pushed.
    assign w_occupancy = {1'b0, r_count} + {1'b0, r_inflight};

    assign imem_req_valid = !reset && !redirect_valid && (w_occupancy < c_depth);
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_resp_ok   = imem_resp_valid && (r_inflight != '0);
    // Responses belonging to a flushed fetch stream are discarded, including
    // one that coincides with the redirect itself.
    assign w_resp_drop = w_resp_ok && ((r_drop_cnt != '0) || redirect_valid);
    assign w_push      = w_resp_ok && !w_resp_drop;

    assign id_valid = !reset && (r_count != '0) && !redirect_valid;
    assign id_pc    = r_pc_mem[r_rd_ptr];
    assign id_instr = r_instr_mem[r_rd_ptr];
    assign w_pop    = id_valid && id_ready;

    assign w_redirect_aligned     = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_unused_redirect_lsbs = ^redirect_pc[1:0];

    // Outstanding requests after this cycle's issue and response.
    always_comb begin
        w_inflight_next = r_inflight;
        case ({w_req_fire, w_resp_ok})
            2'b10:   w_inflight_next = r_inflight + c_cnt_w'(1);
            2'b01:   w_inflight_next = r_inflight - c_cnt_w'(1);
            default: w_inflight_next = r_inflight;
        endcase
    end

    // ------------------------------------------------------------------
    // Fetch / response / FIFO control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_inflight <= w_inflight_next;
            if (redirect_valid) begin
                // No issue or pop happens in a redirect cycle, so every
                // request still outstanding after this edge is stale.
                r_fetch_pc <= w_redirect_aligned;
                r_resp_pc  <= w_redirect_aligned;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
                r_drop_cnt <= w_inflight_next;
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + XLEN'(4);
                end
                if (w_push) begin
                    r_wr_ptr  <= r_wr_ptr + c_ptr_w'(1);
                    r_resp_pc <= r_resp_pc + XLEN'(4);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + c_cnt_w'(1);
                    2'b01:   r_count <= r_count - c_cnt_w'(1);
                    default: r_count <= r_count;
                endcase
                if (w_resp_ok && (r_drop_cnt != '0)) begin
                    r_drop_cnt <= r_drop_cnt - c_cnt_w'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage. Cleared on reset so the head outputs read as zero
    // while reset is asserted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_pc_mem[i]    <= '0;
                r_instr_mem[i] <= '0;
            end
        end else if (w_push && !redirect_valid) begin
            r_pc_mem[r_wr_ptr]    <= r_resp_pc;
            r_instr_mem[r_wr_ptr] <= imem_resp_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_unit.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : tb_if_prefetch_unit
// Description : Self-checking bench for if_prefetch_unit. A behavioural
//               instruction memory answers accepted requests in order after
//               a chosen latency; each accepted request pushes its expected
//               {pc, instr} into a scoreboard queue that ID pops compare
//               against. Redirect and reset clear the scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_prefetch_unit;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    if_prefetch_unit #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_pc           (id_pc),
        .id_instr        (id_instr),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
    );

    typedef struct { logic [31:0] data; int due; } mem_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

    mem_t        pend[$];
    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          last_due = 0;
    int          lat_fix  = 1;
    bit          lat_rand = 0;
    bit          rdy_rand = 0;
    bit          idr_rand = 0;
    int          req_cnt  = 0;
    int          pop_cnt  = 0;
    logic [31:0] exp_addr;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: sample handshakes at the falling edge, then advance
    // the memory model just after the rising edge.
    task automatic tick();
        bit   fire;
        bit   pop;
        mem_t m;
        exp_t e;
        @(negedge clk);
        if (!reset) begin
            fire = imem_req_valid && imem_req_ready;
            pop  = id_valid && id_ready;
            if (redirect_valid) begin
                check_eq("redir_req_valid", 32'(imem_req_valid), 0);
                check_eq("redir_id_valid", 32'(id_valid), 0);
            end
            if (fire) begin
                check_eq("req_addr", imem_req_addr, exp_addr);
                m.data = instr_of(imem_req_addr);
                m.due  = cyc + (lat_rand ? int'($urandom_range(1, 3)) : lat_fix);
                if (m.due <= last_due) m.due = last_due + 1;
                last_due = m.due;
                pend.push_back(m);
                e.pc    = imem_req_addr;
                e.instr = m.data;
                exp_q.push_back(e);
                exp_addr += 32'd4;
                req_cnt++;
            end
            if (pop) begin
                if (exp_q.size() == 0) begin
                    check_eq("pop_unexpected", 32'(id_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("id_pc", id_pc, e.pc);
                    check_eq("id_instr", id_instr, e.instr);
                    pop_cnt++;
                end
            end
            check_eq("credit_bound", 32'(exp_q.size() <= int'(DEPTH) && pend.size() <= int'(DEPTH)), 1);
            if (redirect_valid) begin
                exp_q.delete();
                exp_addr = {redirect_pc[31:2], 2'b00};
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            m = pend.pop_front();
            imem_resp_valid = 1'b1;
            imem_resp_data  = m.data;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
        if (rdy_rand) imem_req_ready = 1'($urandom_range(0, 1));
        if (idr_rand) id_ready = ($urandom_range(0, 9) < 7);
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        rdy_rand = 0;
        idr_rand = 0;
        lat_rand = 0;
        imem_req_ready = 1'b0;
        id_ready = 1'b1;
        n = 0;
        while ((exp_q.size() > 0 || pend.size() > 0) && n < 60) begin
            tick();
            n++;
        end
        tick();
        check_eq(tag, 32'(exp_q.size() + pend.size()), 0);
        check_eq({tag, "_id_idle"}, 32'(id_valid), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int r0;
        int p0;
        int n;
        reset           = 1'b1;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        id_ready        = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        exp_addr        = RESET_PC;

        // Reset values
        #7;
        check_eq("rst_req_valid", 32'(imem_req_valid), 0);
        check_eq("rst_id_valid", 32'(id_valid), 0);
        check_eq("rst_req_addr", imem_req_addr, RESET_PC);
        check_eq("rst_id_pc", id_pc, 0);
        check_eq("rst_id_instr", id_instr, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_eq("first_req_valid", 32'(imem_req_valid), 1);
        check_eq("first_req_addr", imem_req_addr, RESET_PC);

        // Streaming, 1-cycle latency: one instruction per cycle
        lat_fix = 1;
        for (int i = 0; i < 20; i++) begin
            if (i == 4) p0 = pop_cnt;
            tick();
        end
        check_eq("throughput", 32'(pop_cnt - p0), 16);

        // Stall: ID not ready for 10 cycles after restarting at 0
        id_ready = 1'b0;
        do_redirect(32'h0000_0000);
        r0 = req_cnt;
        repeat (10) tick();
        check_eq("stall_reqs", 32'(req_cnt - r0), 4);
        check_eq("stall_req_valid", 32'(imem_req_valid), 0);
        check_eq("stall_id_valid", 32'(id_valid), 1);
        check_eq("stall_resume_addr", exp_addr, 32'h10);
        id_ready = 1'b1;
        repeat (12) tick();

        // Redirect with latency-3 requests outstanding
        lat_fix = 3;
        repeat (8) tick();
        check_eq("pre_redir_pending", 32'(pend.size() >= 2), 1);
        do_redirect(32'h0000_0100);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("flush_empty", 32'(id_valid), 0);
        end
        p0 = pop_cnt;
        repeat (10) tick();
        check_eq("post_redir_pops", 32'(pop_cnt > p0), 1);

        // Misaligned redirect coinciding with a response and a ready ID
        lat_fix = 1;
        repeat (6) tick();
        check_eq("coinc_resp_valid", 32'(imem_resp_valid), 1);
        check_eq("coinc_id_valid_before", 32'(id_valid), 1);
        do_redirect(32'h0000_0203);
        check_eq("aligned_redirect_addr", imem_req_addr, 32'h200);
        repeat (10) tick();

        // Random memory readiness, latency and ID backpressure
        rdy_rand = 1;
        lat_rand = 1;
        idr_rand = 1;
        repeat (200) tick();
        drain("random_drain");

        // Mid-stream reset: 3 buffered, 1 in flight with a long latency
        id_ready = 1'b0;
        do_redirect(32'h0000_0040);
        lat_fix = 3;
        imem_req_ready = 1'b1;
        repeat (3) tick();
        lat_fix = 8;
        tick();
        imem_req_ready = 1'b0;
        repeat (2) tick();
        check_eq("pre_rst_id_valid", 32'(id_valid), 1);
        check_eq("pre_rst_pending", 32'(pend.size()), 1);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_req_valid", 32'(imem_req_valid), 0);
        check_eq("mid_rst_id_valid", 32'(id_valid), 0);
        check_eq("mid_rst_req_addr", imem_req_addr, RESET_PC);
        check_eq("mid_rst_id_pc", id_pc, 0);
        check_eq("mid_rst_id_instr", id_instr, 0);
        exp_q.delete();
        exp_addr = RESET_PC;
        tick();
        reset = 1'b0;
        #1;
        check_eq("post_rst_req_valid", 32'(imem_req_valid), 1);
        check_eq("post_rst_req_addr", imem_req_addr, RESET_PC);
        n = 0;
        while (pend.size() > 0 && n < 20) begin
            tick();
            check_eq("stale_ignored", 32'(id_valid), 0);
            n++;
        end
        tick();
        check_eq("stale_ignored_final", 32'(id_valid), 0);
        check_eq("stale_timeout", 32'(pend.size()), 0);
        imem_req_ready = 1'b1;
        id_ready = 1'b1;
        lat_fix = 1;
        p0 = pop_cnt;
        repeat (12) tick();
        check_eq("post_rst_pops", 32'(pop_cnt - p0 >= 8), 1);
        drain("final_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
